// File: rtl/cache_writeback_serializer_if.sv
// Bus between the cache miss path, the writeback serializer and the
// byte-wide memory write port. The serializer uses the slave view; the
// cache/memory side that drives the request and consumes bytes uses master.
interface cache_writeback_serializer_if #(
  parameter int BLOCK_BYTES = 32,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 32
);
  logic                          start;
  logic                          dirty;
  logic [BLOCK_BYTES*DATA_W-1:0] blockIn;
  logic [ADDR_W-1:0]             blockAddr;
  logic                          memReady;
  logic [DATA_W-1:0]             memData;
  logic [ADDR_W-1:0]             memAddr;
  logic                          memWrite;
  logic [BLOCK_BYTES-1:0]        decOut;
  logic                          stall;
  logic                          done;

  modport master (
    output start, dirty, blockIn, blockAddr, memReady,
    input  memData, memAddr, memWrite, decOut, stall, done
  );

  modport slave (
    input  start, dirty, blockIn, blockAddr, memReady,
    output memData, memAddr, memWrite, decOut, stall, done
  );
endinterface

// File: rtl/cache_writeback_serializer.sv
// Writeback serializer: latches a dirty victim block on eviction and streams
// it to memory one byte per accepted cycle, stalling the pipeline meanwhile.
// Every output is decoded from registered state only.
module cache_writeback_serializer #(
  parameter int BLOCK_BYTES = 32,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 32
) (
  input logic clk,
  input logic reset,
  cache_writeback_serializer_if.slave bus
);
  localparam int CNT_W   = $clog2(BLOCK_BYTES);
  localparam int BLOCK_W = BLOCK_BYTES * DATA_W;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [BLOCK_W-1:0] shiftbuf_q, shiftbuf_d;
  logic [ADDR_W-1:0]  base_q, base_d;

  // State register; reset abandons any transfer in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      shiftbuf_q <= '0;
      base_q     <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      shiftbuf_q <= shiftbuf_d;
      base_q     <= base_d;
    end
  end

  // Next-state logic: accept an eviction, then shift one byte out per accepted write
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    shiftbuf_d = shiftbuf_q;
    base_d     = base_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.dirty) begin
            shiftbuf_d = bus.blockIn;
            base_d     = bus.blockAddr & ~ADDR_W'(BLOCK_BYTES - 1);
            count_d    = '0;
            state_d    = SEND;
          end else begin
            state_d = DONE;
          end
        end
      end
      SEND: begin
        if (bus.memReady) begin
          if (count_q == CNT_W'(BLOCK_BYTES - 1)) begin
            state_d = DONE;
          end else begin
            count_d    = count_q + 1'b1;
            shiftbuf_d = shiftbuf_q >> DATA_W;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Moore outputs; the low byte of the shift buffer is always the current byte
  always_comb begin
    bus.memWrite = 1'b0;
    bus.stall    = 1'b0;
    bus.done     = 1'b0;
    bus.memData  = '0;
    bus.memAddr  = '0;
    bus.decOut   = '0;
    case (state_q)
      SEND: begin
        bus.memWrite = 1'b1;
        bus.stall    = 1'b1;
        bus.memData  = shiftbuf_q[DATA_W-1:0];
        bus.memAddr  = base_q | ADDR_W'(count_q);
        bus.decOut   = BLOCK_BYTES'(1) << count_q;
      end
      DONE: begin
        bus.done = 1'b1;
      end
      default: begin
      end
    endcase
  end
endmodule

// File: tb/tb_cache_writeback_serializer.sv
// Directed testbench for the writeback serializer: full writeback, clean
// eviction, memory backpressure, async reset mid-transfer, ignored start
// during a transfer and back-to-back evictions.
module tb_cache_writeback_serializer;
  logic clk;
  logic reset;
  int   checkCount;
  int   errorCount;
  int   stallCycles;
  int   doneCycles;
  int   writeCycles;

  logic [255:0] blkA;
  logic [255:0] blkB;
  logic [255:0] blkC;
  int           s0;
  int           d0;
  int           w0;

  cache_writeback_serializer_if bus ();

  cache_writeback_serializer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count stall, done and write cycles mid-cycle for the latency checks
  always @(negedge clk) begin
    if (!reset) begin
      stallCycles += int'(bus.stall);
      doneCycles  += int'(bus.done);
      writeCycles += int'(bus.memWrite);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic dt,
                               input logic [255:0] blk, input logic [31:0] addr,
                               input logic rdy);
    bus.start     = st;
    bus.dirty     = dt;
    bus.blockIn   = blk;
    bus.blockAddr = addr;
    bus.memReady  = rdy;
  endtask

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".memWrite"}, 32'(bus.memWrite), 32'd0);
    checkOutput({tag, ".stall"}, 32'(bus.stall), 32'd0);
    checkOutput({tag, ".done"}, 32'(bus.done), 32'd0);
    checkOutput({tag, ".decOut"}, bus.decOut, 32'd0);
  endtask

  // Walks a transfer that has just been accepted; holdCycles of memReady=0 are
  // inserted at holdByte, and a competing start is pulsed at injectByte
  task automatic sendAndCheck(input string tag, input logic [255:0] blk,
                              input logic [31:0] baseAddr, input int holdByte,
                              input int holdCycles, input int injectByte);
    int reps;
    for (int b = 0; b < 32; b++) begin
      reps = (b == holdByte) ? holdCycles + 1 : 1;
      for (int h = 0; h < reps; h++) begin
        bus.memReady = (h == reps - 1);
        if (b == injectByte && h == 0) begin
          bus.start   = 1'b1;
          bus.dirty   = 1'b1;
          bus.blockIn = ~blk;
        end else if (injectByte >= 0 && b == injectByte + 1 && h == 0) begin
          bus.start = 1'b0;
        end
        checkOutput($sformatf("%s.b%0d.memWrite", tag, b), 32'(bus.memWrite), 32'd1);
        checkOutput($sformatf("%s.b%0d.stall", tag, b), 32'(bus.stall), 32'd1);
        checkOutput($sformatf("%s.b%0d.memData", tag, b), 32'(bus.memData), 32'(blk[8*b +: 8]));
        checkOutput($sformatf("%s.b%0d.memAddr", tag, b), bus.memAddr, baseAddr + 32'(b));
        checkOutput($sformatf("%s.b%0d.decOut", tag, b), bus.decOut, 32'd1 << b);
        waitCycle();
      end
    end
    bus.memReady = 1'b1;
    checkOutput({tag, ".doneHigh"}, 32'(bus.done), 32'd1);
    checkOutput({tag, ".doneStall"}, 32'(bus.stall), 32'd0);
    checkOutput({tag, ".doneWrite"}, 32'(bus.memWrite), 32'd0);
    checkOutput({tag, ".doneDec"}, bus.decOut, 32'd0);
  endtask

  initial begin
    checkCount  = 0;
    errorCount  = 0;
    stallCycles = 0;
    doneCycles  = 0;
    writeCycles = 0;
    for (int k = 0; k < 32; k++) begin
      blkA[8*k +: 8] = 8'(k);
      blkB[8*k +: 8] = 8'(8'hFF - k);
      blkC[8*k +: 8] = 8'(8'h40 + 3 * k);
    end

    // Reset state
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
    reset = 1'b1;
    #23;
    checkIdle("reset");
    checkOutput("reset.memData", 32'(bus.memData), 32'd0);
    checkOutput("reset.memAddr", bus.memAddr, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    waitCycle();

    // Scenario 1: full dirty writeback with memReady held high
    $display("[TB] scenario 1: dirty writeback");
    s0 = stallCycles; d0 = doneCycles; w0 = writeCycles;
    applyStimulus(1'b1, 1'b1, blkA, 32'h0000_0062, 1'b1);
    waitCycle();
    bus.start = 1'b0;
    sendAndCheck("s1", blkA, 32'h0000_0060, -1, 0, -1);
    waitCycle();
    checkIdle("s1.idle");
    checkOutput("s1.stallCycles", 32'(stallCycles - s0), 32'd32);
    checkOutput("s1.writeCycles", 32'(writeCycles - w0), 32'd32);
    checkOutput("s1.doneCycles", 32'(doneCycles - d0), 32'd1);

    // Scenario 2: clean eviction produces only a done pulse
    $display("[TB] scenario 2: clean eviction");
    s0 = stallCycles; d0 = doneCycles; w0 = writeCycles;
    applyStimulus(1'b1, 1'b0, blkB, 32'h0000_1000, 1'b1);
    waitCycle();
    bus.start = 1'b0;
    checkOutput("s2.done", 32'(bus.done), 32'd1);
    checkOutput("s2.stall", 32'(bus.stall), 32'd0);
    checkOutput("s2.memWrite", 32'(bus.memWrite), 32'd0);
    waitCycle();
    checkIdle("s2.idle");
    waitCycle();
    checkOutput("s2.stallCycles", 32'(stallCycles - s0), 32'd0);
    checkOutput("s2.writeCycles", 32'(writeCycles - w0), 32'd0);
    checkOutput("s2.doneCycles", 32'(doneCycles - d0), 32'd1);

    // Scenario 3: three cycles of backpressure at byte 5
    $display("[TB] scenario 3: backpressure");
    s0 = stallCycles; d0 = doneCycles;
    applyStimulus(1'b1, 1'b1, blkA, 32'h0000_0062, 1'b1);
    waitCycle();
    bus.start = 1'b0;
    sendAndCheck("s3", blkA, 32'h0000_0060, 5, 3, -1);
    waitCycle();
    checkIdle("s3.idle");
    checkOutput("s3.stallCycles", 32'(stallCycles - s0), 32'd35);
    checkOutput("s3.doneCycles", 32'(doneCycles - d0), 32'd1);

    // Scenario 4: asynchronous reset while byte 10 is on the bus
    $display("[TB] scenario 4: async reset mid-transfer");
    applyStimulus(1'b1, 1'b1, blkA, 32'h0000_0062, 1'b1);
    waitCycle();
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) waitCycle();
    checkOutput("s4.preByte", 32'(bus.memData), 32'h0A);
    #2;
    reset = 1'b1;
    #1;
    checkIdle("s4.reset");
    checkOutput("s4.memData", 32'(bus.memData), 32'd0);
    #3;
    reset = 1'b0;
    waitCycle();
    checkIdle("s4.after");
    applyStimulus(1'b1, 1'b1, blkC, 32'hFFFF_FFFF, 1'b1);
    waitCycle();
    bus.start = 1'b0;
    sendAndCheck("s4.new", blkC, 32'hFFFF_FFE0, -1, 0, -1);
    waitCycle();
    checkIdle("s4.idle");

    // Scenario 5: competing start with another block at byte 15 is ignored
    $display("[TB] scenario 5: start ignored during SEND");
    d0 = doneCycles;
    applyStimulus(1'b1, 1'b1, blkB, 32'h0000_2345, 1'b1);
    waitCycle();
    bus.start = 1'b0;
    sendAndCheck("s5", blkB, 32'h0000_2340, -1, 0, 15);
    waitCycle();
    checkIdle("s5.idle");
    waitCycle();
    checkIdle("s5.idle2");
    checkOutput("s5.doneCycles", 32'(doneCycles - d0), 32'd1);

    // Scenario 6: start held high, A then B back to back
    $display("[TB] scenario 6: back-to-back evictions");
    d0 = doneCycles;
    applyStimulus(1'b1, 1'b1, blkA, 32'h1234_5678, 1'b1);
    waitCycle();
    bus.blockIn   = blkB;
    bus.blockAddr = 32'hABCD_EF9F;
    sendAndCheck("s6.A", blkA, 32'h1234_5660, -1, 0, -1);
    waitCycle();
    checkIdle("s6.gap");
    waitCycle();
    bus.start = 1'b0;
    sendAndCheck("s6.B", blkB, 32'hABCD_EF80, -1, 0, -1);
    waitCycle();
    checkIdle("s6.idle");
    checkOutput("s6.doneCycles", 32'(doneCycles - d0), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end
endmodule
